mul_pipe: RTL and testbench

Parametrised, fully pipelined radix-4 Booth / Wallace-tree multiplier with valid/ready handshake, per-operation signed/unsigned mode, tag passthrough and pipeline flush. It sits in the execute stage behind the MULT/MULTU/MUL issue logic. It replaces the fixed 32-bit, fixed 2-cycle multiplier with a block that tolerates writeback backpressure and exception-driven kills.

---
 rtl/mul_pipe_if.sv | 30 +++
 rtl/mul_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_mul_pipe.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pipe_if.sv
// mul_pipe_if: handshake bundle for the pipelined multiplier.
//   in_*   : operation offer (valid/ready, signed mode, operands, sideband tag)
//   out_*  : completed product (valid/ready, 2*WIDTH result, tag)
// master : the issuing/consuming side (issue logic + writeback)
// slave  : the multiplier
interface mul_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_signed;
  logic [WIDTH-1:0]     in_x;
  logic [WIDTH-1:0]     in_y;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_result;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_signed, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined radix-4 Booth / Wallace-tree multiplier.
//   mul_clk : clock, rising edge
//   resetn  : asynchronous active-low reset
//   flush   : synchronous kill of every in-flight operation (overrides stall)
//   bus     : mul_pipe_if slave (operation in, product out, valid/ready both sides)
// Parameters: WIDTH even in 4..64, STAGES 2 or 3, TAG_W tag width.
// Operands are captured on accept; then S1 = Booth generation, (STAGES=3: S2 = tree to
// sum/carry), last stage = remaining tree + carry-propagate add. A result appears STAGES
// edges after the accepting edge. Any output stall freezes the whole pipe.
module mul_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input logic       mul_clk,
  input logic       resetn,
  input logic       flush,
  mul_pipe_if.slave bus
);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int          NPP  = WIDTH / 2 + 1;  // Booth partial products
  localparam int          NOPS = NPP + 1;        // plus one vector of +1 corrections

  typedef logic [PW-1:0] vec_t;

  logic stall, adv, accept;

  logic out_valid_q;
  vec_t out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign adv          = ~stall;
  assign accept       = bus.in_valid & ~stall & ~flush;
  assign bus.in_ready = ~stall;

  // Operand capture register
  logic             op_valid_q, op_signed_q;
  logic [WIDTH-1:0] op_x_q, op_y_q;
  logic [TAG_W-1:0] op_tag_q;

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      op_valid_q  <= 1'b0;
      op_signed_q <= 1'b0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      op_tag_q    <= '0;
    end else if (flush) begin
      op_valid_q <= 1'b0;
    end else if (adv) begin
      op_valid_q <= accept;
      if (accept) begin
        op_signed_q <= bus.in_signed;
        op_x_q      <= bus.in_x;
        op_y_q      <= bus.in_y;
        op_tag_q    <= bus.in_tag;
      end
    end
  end

  // S1: Booth partial-product generation
  vec_t             xe, x2e, booth_mag;
  logic             booth_neg, y_ext;
  logic [WIDTH+2:0] ye;
  vec_t             pp_d [NOPS];

  always_comb begin
    xe        = op_signed_q ? {{WIDTH{op_x_q[WIDTH-1]}}, op_x_q} : {{WIDTH{1'b0}}, op_x_q};
    x2e       = xe << 1;
    y_ext     = op_signed_q & op_y_q[WIDTH-1];
    ye        = {y_ext, y_ext, op_y_q, 1'b0};
    booth_mag = '0;
    booth_neg = 1'b0;
    for (int k = 0; k < NOPS; k++) pp_d[k] = '0;
    for (int i = 0; i < NPP; i++) begin
      booth_mag = '0;
      booth_neg = 1'b0;
      case (ye[2*i +: 3])
        3'b001, 3'b010: booth_mag = xe;
        3'b011:         booth_mag = x2e;
        3'b100:         begin booth_mag = x2e; booth_neg = 1'b1; end
        3'b101, 3'b110: begin booth_mag = xe;  booth_neg = 1'b1; end
        default:        ;
      endcase
      // -m << s == (~m << s) + (1 << s); the +1 lands in the shared correction row
      pp_d[i]           = (booth_neg ? ~booth_mag : booth_mag) << (2 * i);
      pp_d[NPP][2 * i]  = booth_neg;
    end
  end

  logic             s1_valid_q;
  logic [TAG_W-1:0] s1_tag_q;
  vec_t             pp_q [NOPS];

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      for (int k = 0; k < NOPS; k++) pp_q[k] <= '0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= op_valid_q;
      if (op_valid_q) begin
        s1_tag_q <= op_tag_q;
        pp_q     <= pp_d;
      end
    end
  end

  // Wallace reduction: each level folds groups of three rows into sum/carry pairs until
  // two rows remain. The level count is bounded by NOPS; spare iterations do nothing.
  vec_t tr_a [NOPS];
  vec_t tr_b [NOPS];
  int   tr_n, tr_m, tr_base;
  vec_t tree_sum, tree_carry;

  always_comb begin
    tr_a    = pp_q;
    for (int k = 0; k < NOPS; k++) tr_b[k] = '0;
    tr_n    = NOPS;
    tr_m    = 0;
    tr_base = 0;
    for (int l = 0; l < NOPS; l++) begin
      if (tr_n > 2) begin
        tr_m = 0;
        for (int g = 0; g < NOPS / 3; g++) begin
          if (g < tr_n / 3) begin
            tr_b[tr_m]     = tr_a[3*g] ^ tr_a[3*g+1] ^ tr_a[3*g+2];
            tr_b[tr_m + 1] = ((tr_a[3*g] & tr_a[3*g+1]) | (tr_a[3*g] & tr_a[3*g+2]) |
                              (tr_a[3*g+1] & tr_a[3*g+2])) << 1;
            tr_m           = tr_m + 2;
          end
        end
        tr_base = 3 * (tr_n / 3);
        for (int j = 0; j < 2; j++) begin
          if (tr_base + j < tr_n) begin
            tr_b[tr_m] = tr_a[tr_base + j];
            tr_m       = tr_m + 1;
          end
        end
        tr_a = tr_b;
        tr_n = tr_m;
      end
    end
    tree_sum   = tr_a[0];
    tree_carry = tr_a[1];
  end

  logic             fin_valid;
  logic [TAG_W-1:0] fin_tag;
  vec_t             fin_sum, fin_carry;

  if (STAGES == 3) begin : g_stage3
    logic             s2_valid_q;
    logic [TAG_W-1:0] s2_tag_q;
    vec_t             s2_sum_q, s2_carry_q;

    always_ff @(posedge mul_clk or negedge resetn) begin
      if (!resetn) begin
        s2_valid_q <= 1'b0;
        s2_tag_q   <= '0;
        s2_sum_q   <= '0;
        s2_carry_q <= '0;
      end else if (flush) begin
        s2_valid_q <= 1'b0;
      end else if (adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_tag_q   <= s1_tag_q;
          s2_sum_q   <= tree_sum;
          s2_carry_q <= tree_carry;
        end
      end
    end

    assign fin_valid = s2_valid_q;
    assign fin_tag   = s2_tag_q;
    assign fin_sum   = s2_sum_q;
    assign fin_carry = s2_carry_q;
  end else begin : g_stage2
    assign fin_valid = s1_valid_q;
    assign fin_tag   = s1_tag_q;
    assign fin_sum   = tree_sum;
    assign fin_carry = tree_carry;
  end

  // Final carry-propagate add and output register
  vec_t result_d;
  assign result_d = fin_sum + fin_carry;

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fin_valid;
      if (fin_valid) begin
        out_result_q <= result_d;
        out_tag_q    <= fin_tag;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: a WIDTH=32/STAGES=2 instance and a WIDTH=16/STAGES=3 instance.
module tb_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;
  logic flush_a, flush_b;

  mul_pipe_if #(.WIDTH(32), .TAG_W(5)) bus_a ();
  mul_pipe_if #(.WIDTH(16), .TAG_W(5)) bus_b ();

  mul_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut_a (
    .mul_clk (clk),
    .resetn  (resetn),
    .flush   (flush_a),
    .bus     (bus_a)
  );

  mul_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(5)) u_dut_b (
    .mul_clk (clk),
    .resetn  (resetn),
    .flush   (flush_b),
    .bus     (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk64(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", nm, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_a(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] a, b;
    a = s ? {{32{x[31]}}, x} : {32'b0, x};
    b = s ? {{32{y[31]}}, y} : {32'b0, y};
    return a * b;
  endfunction

  function automatic logic [31:0] ref_b(input logic s, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] a, b;
    a = s ? {{16{x[15]}}, x} : {16'b0, x};
    b = s ? {{16{y[15]}}, y} : {16'b0, y};
    return a * b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated op on instance A: accept edge N, nothing at N+1, result at N+2
  task automatic run_a(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input logic [63:0] exp, input string nm);
    bus_a.in_valid  = 1'b1;
    bus_a.in_signed = s;
    bus_a.in_x      = x;
    bus_a.in_y      = y;
    bus_a.in_tag    = t;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    chk1({nm, "_early"}, bus_a.out_valid, 1'b0);
    tick();
    chk1({nm, "_valid"}, bus_a.out_valid, 1'b1);
    chk64({nm, "_res"}, bus_a.out_result, exp);
    chk64({nm, "_tag"}, 64'(bus_a.out_tag), 64'(t));
  endtask

  // One isolated op on instance B: result three edges after accept
  task automatic run_b(input logic s, input logic [15:0] x, input logic [15:0] y,
                       input logic [4:0] t, input logic [31:0] exp, input string nm);
    bus_b.in_valid  = 1'b1;
    bus_b.in_signed = s;
    bus_b.in_x      = x;
    bus_b.in_y      = y;
    bus_b.in_tag    = t;
    tick();
    bus_b.in_valid = 1'b0;
    tick();
    tick();
    chk1({nm, "_early"}, bus_b.out_valid, 1'b0);
    tick();
    chk1({nm, "_valid"}, bus_b.out_valid, 1'b1);
    chk64({nm, "_res"}, 64'(bus_b.out_result), 64'(exp));
    chk64({nm, "_tag"}, 64'(bus_b.out_tag), 64'(t));
  endtask

  initial begin
    logic [63:0] qa_res [$];
    logic [4:0]  qa_tag [$];
    logic [31:0] qb_res [$];
    logic [4:0]  qb_tag [$];
    logic        s;
    logic [31:0] x, y;
    logic [15:0] xb, yb;
    logic [4:0]  t;
    int          got;

    resetn          = 1'b0;
    flush_a         = 1'b0;
    flush_b         = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_signed = 1'b0;
    bus_a.in_x      = '0;
    bus_a.in_y      = '0;
    bus_a.in_tag    = '0;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.in_signed = 1'b0;
    bus_b.in_x      = '0;
    bus_b.in_y      = '0;
    bus_b.in_tag    = '0;
    bus_b.out_ready = 1'b1;

    #3;
    chk1("reset_valid", bus_a.out_valid, 1'b0);
    chk64("reset_result", bus_a.out_result, 64'd0);
    chk64("reset_tag", 64'(bus_a.out_tag), 64'd0);
    chk1("reset_valid_b", bus_b.out_valid, 1'b0);
    #9 resetn = 1'b1;
    #1;
    chk1("reset_in_ready", bus_a.in_ready, 1'b1);

    // Mode corners
    run_a(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 64'hFFFF_FFFE_0000_0001, "u_ff_ff");
    run_a(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 64'h0000_0000_0000_0001, "s_ff_ff");
    run_a(1'b1, 32'h8000_0000, 32'h8000_0000, 5'd3, 64'h4000_0000_0000_0000, "s_80_80");
    run_a(1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, "s_m1_2");
    run_a(1'b0, 32'h8000_0000, 32'h0000_0002, 5'd5, 64'h0000_0001_0000_0000, "u_80_2");
    run_b(1'b0, 16'hFFFF, 16'hFFFF, 5'd6, 32'hFFFE_0001, "b_u_ff_ff");
    run_b(1'b1, 16'h8000, 16'h7FFF, 5'd7, 32'hC000_8000, "b_s_80_7f");

    // Streaming on A: one accept per cycle, results in order one per cycle
    got = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        s = 1'($urandom_range(1));
        x = $urandom();
        y = $urandom();
        t = 5'($urandom_range(31));
        bus_a.in_valid  = 1'b1;
        bus_a.in_signed = s;
        bus_a.in_x      = x;
        bus_a.in_y      = y;
        bus_a.in_tag    = t;
        qa_res.push_back(ref_a(s, x, y));
        qa_tag.push_back(t);
      end else begin
        bus_a.in_valid = 1'b0;
      end
      tick();
      if (bus_a.out_valid) begin
        chk1("a_stream_expected", qa_res.size() != 0, 1'b1);
        if (qa_res.size() != 0) begin
          chk64("a_stream_res", bus_a.out_result, qa_res.pop_front());
          chk64("a_stream_tag", 64'(bus_a.out_tag), 64'(qa_tag.pop_front()));
          got++;
        end
      end
    end
    chk64("a_stream_count", 64'(got), 64'd20);

    // Streaming on B
    got = 0;
    for (int i = 0; i < 13; i++) begin
      if (i < 10) begin
        s  = 1'($urandom_range(1));
        xb = 16'($urandom());
        yb = 16'($urandom());
        t  = 5'($urandom_range(31));
        bus_b.in_valid  = 1'b1;
        bus_b.in_signed = s;
        bus_b.in_x      = xb;
        bus_b.in_y      = yb;
        bus_b.in_tag    = t;
        qb_res.push_back(ref_b(s, xb, yb));
        qb_tag.push_back(t);
      end else begin
        bus_b.in_valid = 1'b0;
      end
      tick();
      if (bus_b.out_valid) begin
        chk1("b_stream_expected", qb_res.size() != 0, 1'b1);
        if (qb_res.size() != 0) begin
          chk64("b_stream_res", 64'(bus_b.out_result), 64'(qb_res.pop_front()));
          chk64("b_stream_tag", 64'(bus_b.out_tag), 64'(qb_tag.pop_front()));
          got++;
        end
      end
    end
    chk64("b_stream_count", 64'(got), 64'd10);

    // Backpressure: two ops in flight, consumer stalls for five cycles
    tick();
    bus_a.in_valid  = 1'b1;
    bus_a.in_signed = 1'b0;
    bus_a.in_x      = 32'd1000;
    bus_a.in_y      = 32'd3000;
    bus_a.in_tag    = 5'd10;
    tick();
    bus_a.in_signed = 1'b1;
    bus_a.in_x      = 32'hFFFF_0000;
    bus_a.in_y      = 32'h0000_0010;
    bus_a.in_tag    = 5'd11;
    tick();
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk1("bp_in_ready", bus_a.in_ready, 1'b0);
      chk1("bp_valid", bus_a.out_valid, 1'b1);
      chk64("bp_res", bus_a.out_result, 64'd3000000);
      chk64("bp_tag", 64'(bus_a.out_tag), 64'd10);
      tick();
    end
    bus_a.out_ready = 1'b1;
    #1;
    chk1("bp_ready_back", bus_a.in_ready, 1'b1);
    tick();
    chk1("bp_second_valid", bus_a.out_valid, 1'b1);
    chk64("bp_second_res", bus_a.out_result, 64'hFFFF_FFFF_FFF0_0000);
    chk64("bp_second_tag", 64'(bus_a.out_tag), 64'd11);
    tick();
    chk1("bp_drained", bus_a.out_valid, 1'b0);

    // Flush with tags 1,2 in flight and tag 3 offered
    bus_a.in_valid  = 1'b1;
    bus_a.in_signed = 1'b0;
    bus_a.in_x      = 32'd5;
    bus_a.in_y      = 32'd5;
    bus_a.in_tag    = 5'd1;
    tick();
    bus_a.in_x   = 32'd6;
    bus_a.in_tag = 5'd2;
    tick();
    flush_a      = 1'b1;
    bus_a.in_x   = 32'd7;
    bus_a.in_tag = 5'd3;
    tick();
    flush_a        = 1'b0;
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("flush_valid", bus_a.out_valid, 1'b0);
      tick();
    end
    run_a(1'b0, 32'd8, 32'd9, 5'd4, 64'd72, "flush_tag4");

    // Asynchronous reset with two ops in flight
    bus_a.in_valid  = 1'b1;
    bus_a.in_signed = 1'b0;
    bus_a.in_x      = 32'h0000_1234;
    bus_a.in_y      = 32'h0000_0010;
    bus_a.in_tag    = 5'd5;
    tick();
    bus_a.in_x   = 32'h0000_0055;
    bus_a.in_tag = 5'd6;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    chk1("rst_pre_valid", bus_a.out_valid, 1'b1);
    chk64("rst_pre_res", bus_a.out_result, 64'h0000_0000_0001_2340);
    #3 resetn = 1'b0;
    #1;
    chk1("rst_valid", bus_a.out_valid, 1'b0);
    chk64("rst_result", bus_a.out_result, 64'd0);
    chk64("rst_tag", 64'(bus_a.out_tag), 64'd0);
    tick();
    chk1("rst_hold_valid", bus_a.out_valid, 1'b0);
    #3 resetn = 1'b1;
    run_a(1'b0, 32'd7, 32'd6, 5'd9, 64'd42, "rst_after");
    tick();
    chk1("rst_no_ghost", bus_a.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
